keypad_scanner: RTL and testbench

Drives the columns of a 4x4 matrix keypad one at a time, samples the active-low row lines and debounces presses and releases. Produces the rcBits[7:0] row/column code consumed by the display update logic, plus a key code and a one-cycle press strobe. Sits between the keypad pins and the update/display path.

---
 rtl/keypad_scanner.sv | 175 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, debounce.
// Emits rcBits row/column code, key code and a one-cycle press strobe.
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [7:0] rcBits,
  output logic [3:0] key_code,
  output logic       key_press
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE);

  typedef enum logic [1:0] {
    SCAN,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_t;

  state_t state, state_n;

  logic [3:0]    sync1, sync2;
  logic [3:0]    rows_s;
  logic [3:0]    row_oh;
  logic [CW-1:0] cnt;
  logic          tick;

  logic [1:0]    col_idx, col_idx_n;
  logic [SW-1:0] stab_cnt, stab_cnt_n;
  logic [SW-1:0] stab_inc;
  logic [3:0]    lat_row, lat_row_n;
  logic [1:0]    lat_col, lat_col_n;
  logic [1:0]    row_idx;

  logic [7:0]    rc_n;
  logic [3:0]    kc_n;
  logic          kp_n;

  // Two-flop synchronizer; idles high so reset looks like "released".
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= rows_n;
      sync2 <= sync1;
    end
  end

  assign rows_s = ~sync2;

  // Isolate the lowest set row; ties between rows resolve low.
  assign row_oh = rows_s & (~rows_s + 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

  assign cols_n = ~(4'b0001 << col_idx);

  assign stab_inc = stab_cnt + SW'(1);

  always_comb begin
    row_idx = 2'd0;
    unique case (1'b1)
      lat_row[0]: row_idx = 2'd0;
      lat_row[1]: row_idx = 2'd1;
      lat_row[2]: row_idx = 2'd2;
      lat_row[3]: row_idx = 2'd3;
      default:    row_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_n    = state;
    col_idx_n  = col_idx;
    stab_cnt_n = stab_cnt;
    lat_row_n  = lat_row;
    lat_col_n  = lat_col;
    rc_n       = rcBits;
    kc_n       = key_code;
    kp_n       = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (row_oh != 4'd0) begin
            lat_row_n  = row_oh;
            lat_col_n  = col_idx;
            stab_cnt_n = SW'(1);
            state_n    = DB_PRESS;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end
        DB_PRESS: begin
          if (row_oh == lat_row) begin
            stab_cnt_n = stab_inc;
            if (stab_inc == STAB_MAX) begin
              state_n = HELD;
              rc_n    = {lat_row, 4'b0001 << lat_col};
              kc_n    = {row_idx, lat_col};
              kp_n    = 1'b1;
            end
          end else begin
            stab_cnt_n = '0;
            state_n    = SCAN;
            col_idx_n  = col_idx + 2'd1;
          end
        end
        HELD: begin
          // Another row showing up while held is ignored.
          if (row_oh == 4'd0) begin
            stab_cnt_n = SW'(1);
            state_n    = DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (row_oh == 4'd0) begin
            stab_cnt_n = stab_inc;
            if (stab_inc == STAB_MAX) begin
              state_n   = SCAN;
              col_idx_n = col_idx + 2'd1;
              rc_n      = 8'd0;
            end
          end else begin
            stab_cnt_n = '0;
            state_n    = HELD;
          end
        end
        default: begin
          state_n = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      stab_cnt  <= '0;
      lat_row   <= 4'd0;
      lat_col   <= 2'd0;
      rcBits    <= 8'd0;
      key_code  <= 4'd0;
      key_press <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_idx_n;
      stab_cnt  <= stab_cnt_n;
      lat_row   <= lat_row_n;
      lat_col   <= lat_col_n;
      rcBits    <= rc_n;
      key_code  <= kc_n;
      key_press <= kp_n;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus random key traffic
// checked every cycle against a tick-level behavioural keypad model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [7:0] rcBits;
  logic [3:0] key_code;
  logic       key_press;

  logic [15:0] pressed = '0;

  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;

  int         m_mode = 0;
  int         m_cnt = 0;
  int         m_col = 0;
  int         m_stab = 0;
  int         m_lrow = 0;
  int         m_lcol = 0;
  logic [3:0] m_h1 = 4'hF;
  logic [3:0] m_h2 = 4'hF;
  logic [7:0] m_rc = '0;
  logic [3:0] m_kc = '0;
  logic       m_kp = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rows_n(rows_n),
    .cols_n(cols_n),
    .rcBits(rcBits),
    .key_code(key_code),
    .key_press(key_press)
  );

  // Physical keypad: a pressed key shorts its row to the driven column.
  always_comb begin
    rows_n = 4'hF;
    for (int c = 0; c < 4; c++)
      if (cols_n[c] == 1'b0)
        for (int r = 0; r < 4; r++)
          if (pressed[4*r+c]) rows_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pins(input logic [15:0] pr, input int col);
    logic [3:0] p;
    p = 4'hF;
    for (int r = 0; r < 4; r++)
      if (pr[4*r+col]) p[r] = 1'b0;
    return p;
  endfunction

  task automatic model_edge(input logic [3:0] pin);
    logic [3:0] rs;
    logic [7:0] v;
    int r;
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_col = 0; m_stab = 0;
      m_lrow = 0; m_lcol = 0;
      m_h1 = 4'hF; m_h2 = 4'hF;
      m_rc = '0; m_kc = '0; m_kp = 1'b0;
      return;
    end
    rs = ~m_h2;
    r = -1;
    for (int i = 3; i >= 0; i--)
      if (rs[i]) r = i;
    m_kp = 1'b0;
    if (m_cnt == SD - 1) begin
      case (m_mode)
        0: begin
          if (r >= 0) begin
            m_lrow = r; m_lcol = m_col; m_stab = 1; m_mode = 1;
          end else m_col = (m_col + 1) % 4;
        end
        1: begin
          if (r == m_lrow) begin
            m_stab++;
            if (m_stab == DB) begin
              m_mode = 2;
              v = '0;
              v[4+m_lrow] = 1'b1;
              v[m_lcol] = 1'b1;
              m_rc = v;
              m_kc = 4'(4 * m_lrow + m_lcol);
              m_kp = 1'b1;
            end
          end else begin
            m_stab = 0; m_mode = 0; m_col = (m_col + 1) % 4;
          end
        end
        2: begin
          if (r < 0) begin
            m_stab = 1; m_mode = 3;
          end
        end
        default: begin
          if (r < 0) begin
            m_stab++;
            if (m_stab == DB) begin
              m_mode = 0; m_col = (m_col + 1) % 4; m_rc = '0;
            end
          end else begin
            m_stab = 0; m_mode = 2;
          end
        end
      endcase
    end
    m_h2 = m_h1;
    m_h1 = pin;
    m_cnt = (m_cnt + 1) % SD;
  endtask

  task automatic step();
    logic [3:0] pin;
    logic [3:0] ec;
    pin = pins(pressed, m_col);
    @(posedge clk);
    model_edge(pin);
    #1;
    ec = 4'hF;
    ec[m_col] = 1'b0;
    check("cols_n", 32'(cols_n), 32'(ec));
    check("rcBits", 32'(rcBits), 32'(m_rc));
    check("key_code", 32'(key_code), 32'(m_kc));
    check("key_press", 32'(key_press), 32'(m_kp));
    if (key_press === 1'b1) pulses++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_press(input string tag, input int lim);
    int k;
    k = 0;
    pulses = 0;
    while (pulses == 0 && k < lim) begin
      step();
      k++;
    end
    check(tag, 32'(pulses), 32'd1);
  endtask

  task automatic wait_clear(input string tag, input int lim);
    int k;
    k = 0;
    while (rcBits !== 8'd0 && k < lim) begin
      step();
      k++;
    end
    check(tag, 32'(rcBits), 32'd0);
  endtask

  task automatic wait_mode(input string tag, input int mode, input int lim);
    int k;
    k = 0;
    while (m_mode != mode && k < lim) begin
      step();
      k++;
    end
    check(tag, 32'(k < lim), 32'd1);
  endtask

  task automatic reset_check(input string tag);
    reset = 1'b1;
    pulses = 0;
    step();
    check({tag, "_cols"}, 32'(cols_n), 32'h0000000E);
    check({tag, "_rc"}, 32'(rcBits), 32'd0);
    check({tag, "_code"}, 32'(key_code), 32'd0);
    check({tag, "_kp"}, 32'(key_press), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    int sel, dur, a, b;

    // Idle scanning after reset.
    run(2);
    reset = 1'b0;
    pulses = 0;
    run(40);
    check("t1_no_press", 32'(pulses), 32'd0);

    // Stable press on row 2 / col 1.
    pressed = 16'(1 << 9);
    wait_press("t2_press", 200);
    check("t2_rc", 32'(rcBits), 32'h42);
    check("t2_code", 32'(key_code), 32'd9);
    pulses = 0;
    run(20);
    check("t2_single", 32'(pulses), 32'd0);
    check("t2_col", 32'(cols_n), 32'hD);

    // Release: scanning resumes at the next column.
    pressed = '0;
    wait_clear("t3_clear", 100);
    check("t3_col", 32'(cols_n), 32'hB);

    // Bounce during press debounce is rejected.
    pressed = 16'(1 << 0);
    wait_mode("t4_dbp", 1, 200);
    pressed = '0;
    pulses = 0;
    run(12);
    check("t4_no_press", 32'(pulses), 32'd0);
    pressed = 16'(1 << 0);
    wait_press("t4_press", 200);
    check("t4_rc", 32'(rcBits), 32'h11);
    pressed = '0;
    wait_clear("t4_clear", 100);

    // Two rows in col 0: lowest row wins; extra row while held ignored.
    pressed = 16'((1 << 4) | (1 << 12));
    wait_press("t5_press", 200);
    check("t5_rc", 32'(rcBits), 32'h21);
    check("t5_code", 32'(key_code), 32'd4);
    pressed = pressed | 16'(1 << 8);
    pulses = 0;
    run(20);
    check("t5_hold_rc", 32'(rcBits), 32'h21);
    check("t5_hold_kp", 32'(pulses), 32'd0);
    pressed = '0;
    wait_clear("t5_clear", 100);

    // Reset mid-debounce and while held.
    pressed = 16'(1 << 5);
    wait_mode("t6_dbp", 1, 200);
    reset_check("t6a");
    wait_press("t6_press", 200);
    pressed = '0;
    reset_check("t6b");
    pulses = 0;
    run(30);
    check("t6_quiet", 32'(pulses), 32'd0);

    // Random key traffic.
    for (int it = 0; it < 300; it++) begin
      sel = int'($urandom_range(0, 9));
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      if (sel < 4) pressed = '0;
      else if (sel < 8) pressed = 16'(1 << a);
      else if (sel == 8) pressed = 16'((1 << a) | (1 << b));
      else pressed = 16'($urandom);
      dur = int'($urandom_range(1, 40));
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      run(dur);
    end
    pressed = '0;
    run(60);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
